// File: rtl/seq_div64by32.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// One quotient bit per clock, valid/ready on both the operand and result side.
//
// Handshake: an operand pair is accepted on a rising edge where in_valid and
// in_ready are both 1; a result is taken on a rising edge where out_valid and
// out_ready are both 1. Neither side may change its payload in a way the other
// side depends on while its valid is high and the transfer has not happened.
//
// Timing: the first BUSY cycle (cnt == 0) is a check cycle that decides
// overflow from the latched operands. An overflow result goes straight to
// DONE; otherwise cnt 1..WIDTH perform the WIDTH shift/subtract steps.
module seq_div64by32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero,
    output logic                 ovf,
    output logic [1:0]           state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [WIDTH:0]  p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;

    logic            over;
    logic            check_cyc;
    logic            last_step;
    logic [WIDTH:0]  shifted;
    logic [WIDTH+1:0] diff;
    logic            take_bit;
    logic [WIDTH:0]  p_step;
    logic [WIDTH-1:0] q_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    // Quotient cannot fit in WIDTH bits when the upper half already reaches
    // the divisor; a zero divisor always lands here.
    assign over      = (p[WIDTH-1:0] >= d);
    assign check_cyc = (state == BUSY) && (cnt == '0);
    assign last_step = (state == BUSY) && (cnt == CW'(WIDTH));

    // One restoring step: shift {P,Q} left, trial-subtract D from the
    // WIDTH+1-bit partial remainder, keep the difference when non-negative.
    always_comb begin
        shifted  = {p[WIDTH-1:0], q[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, d};
        take_bit = ~diff[WIDTH+1];
        p_step   = take_bit ? diff[WIDTH:0] : shifted;
        q_step   = {q[WIDTH-2:0], take_bit};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = BUSY;
            BUSY: begin
                if (check_cyc && over) state_nx = DONE;
                else if (last_step)    state_nx = DONE;
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            p         <= '0;
            q         <= '0;
            d         <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                p   <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                q   <= dividend[WIDTH-1:0];
                d   <= divisor;
                cnt <= '0;
            end else if (state == BUSY) begin
                if (check_cyc) begin
                    if (over) begin
                        quotient  <= '1;
                        remainder <= '0;
                        ovf       <= 1'b1;
                        div_zero  <= (d == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    p   <= p_step;
                    q   <= q_step;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        quotient  <= q_step;
                        remainder <= p_step[WIDTH-1:0];
                        ovf       <= 1'b0;
                        div_zero  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div64by32.sv
// Directed and random checks for seq_div64by32 (WIDTH = 32).
module tb_seq_div64by32;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   dividend;
    logic [31:0]   divisor;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   quotient;
    logic [31:0]   remainder;
    logic          div_zero;
    logic          ovf;
    logic [1:0]    state_dbg;

    int n_checks;
    int n_pass;

    seq_div64by32 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one division, wait for the result, check it, then take it after
    // 'stall' extra cycles. elat < 0 skips the latency check.
    task automatic run_div(input string tag, input logic [63:0] dvd, input logic [31:0] dvs,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input logic eovf, input int elat, input int stall);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (elat >= 0) check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".quot"}, 64'(quotient), 64'(eq));
        check({tag, ".rem"}, 64'(remainder), 64'(er));
        check({tag, ".dz"}, 64'(div_zero), 64'(edz));
        check({tag, ".ovf"}, 64'(ovf), 64'(eovf));
        check({tag, ".busy_ready"}, 64'(in_ready), 64'd0);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".taken"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] r_dvd;
        logic [31:0] r_dvs;
        logic [31:0] r_hi;
        logic [31:0] r_eq;
        logic [31:0] r_er;
        logic        r_ovf;
        logic [31:0] hold_q;

        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.quot", 64'(quotient), 64'd0);
        check("rst.rem", 64'(remainder), 64'd0);
        check("rst.flags", 64'({div_zero, ovf}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // Directed vectors.
        run_div("t1_100_7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, W + 1, 0);
        run_div("t2_eim", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, W + 1, 0);
        run_div("t3_dz", 64'h1234_5678_9ABC_DEF0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1, 0);
        run_div("t4_ovf", 64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1, 0);
        run_div("t_hi_below", 64'h0000_0004_FFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0, W + 1, 0);
        run_div("t_div1", 64'h0000_0000_DEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, W + 1, 0);
        run_div("t_zero", 64'd0, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, W + 1, 0);

        // DONE stall: outputs hold, in_valid ignored, then a new operand accepted.
        dividend = 64'd1000;
        divisor  = 32'd33;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (W + 1) @(negedge clk);
        check("t5.valid", 64'(out_valid), 64'd1);
        check("t5.quot", 64'(quotient), 64'd30);
        check("t5.rem", 64'(remainder), 64'd10);
        hold_q   = quotient;
        dividend = 64'd77;
        divisor  = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5.hold_valid", 64'(out_valid), 64'd1);
            check("t5.hold_ready", 64'(in_ready), 64'd0);
            check("t5.hold_quot", 64'(quotient), 64'(hold_q));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5.idle", 64'(in_ready), 64'd1);
        run_div("t5_next", 64'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b0, W + 1, 0);

        // Reset mid-operation aborts; afterwards a division completes normally.
        dividend = 64'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        check("t6.busy", 64'(state_dbg), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6.valid", 64'(out_valid), 64'd0);
        check("t6.quot", 64'(quotient), 64'd0);
        check("t6.rem", 64'(remainder), 64'd0);
        check("t6.state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_div("t6_after", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, W + 1, 0);

        // Random operands with random result stalls.
        for (int i = 0; i < 1000; i++) begin
            r_dvs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 7) == 0 || r_dvs == 0) r_hi = $urandom;
            else r_hi = $urandom % r_dvs;
            r_dvd = {r_hi, 32'($urandom)};
            r_ovf = (r_dvs == 0) || (r_hi >= r_dvs);
            if (r_ovf) begin
                r_eq = 32'hFFFF_FFFF;
                r_er = 32'd0;
            end else begin
                r_eq = 32'(r_dvd / {32'd0, r_dvs});
                r_er = 32'(r_dvd % {32'd0, r_dvs});
            end
            run_div("rnd", r_dvd, r_dvs, r_eq, r_er, r_dvs == 0, r_ovf,
                    r_ovf ? 1 : W + 1, $urandom_range(0, 3));
            if (!r_ovf)
                check("rnd.inv", {32'd0, quotient} * {32'd0, r_dvs} + {32'd0, remainder}, r_dvd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
